// File: rtl/demux_1x2_8bit_seq.sv
// Registered 1-to-2 byte demultiplexer. Routing is either explicit by s, or
// automatic ch0/ch1 alternation that de-interleaves a byte-pair stream and counts pairs.
module demux_1x2_8bit_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             mode,
  input  logic             s,
  input  logic             sync,
  output logic [WIDTH-1:0] o0,
  output logic [WIDTH-1:0] o1,
  output logic             v0,
  output logic             v1,
  output logic             pair_valid,
  output logic             ptr,
  output logic [7:0]       pair_count
);

  logic mode_q;
  logic pending;
  logic realign;
  logic ptr_eff;
  logic pend_eff;
  logic dest;

  function automatic logic [7:0] wrap_inc(input logic [7:0] x);
    return x + 8'd1;
  endfunction

  // A sync request or a mode change restarts the alignment before this cycle's byte routes
  always_comb begin
    realign  = sync | (mode != mode_q);
    ptr_eff  = ptr & ~realign;
    pend_eff = pending & ~realign;
    dest     = mode ? ptr_eff : s;
  end

  // Stage boundary: all outputs registered, latency 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o0         <= '0;
      o1         <= '0;
      v0         <= 1'b0;
      v1         <= 1'b0;
      pair_valid <= 1'b0;
      ptr        <= 1'b0;
      pending    <= 1'b0;
      pair_count <= 8'd0;
      mode_q     <= 1'b0;
    end else begin
      mode_q     <= mode;
      v0         <= 1'b0;
      v1         <= 1'b0;
      pair_valid <= 1'b0;
      ptr        <= ptr_eff;
      pending    <= pend_eff;
      if (din_valid) begin
        if (!dest) begin
          o0 <= din;
          v0 <= 1'b1;
        end else begin
          o1 <= din;
          v1 <= 1'b1;
        end
        if (mode) begin
          if (!dest) begin
            ptr     <= 1'b1;
            pending <= 1'b1;
          end else begin
            ptr     <= 1'b0;
            pending <= 1'b0;
            if (pend_eff) begin
              pair_valid <= 1'b1;
              pair_count <= wrap_inc(pair_count);
            end
          end
        end
      end
    end
  end

endmodule

// File: doc/demux_1x2_8bit_seq.md
# demux_1x2_8bit_seq

Registered 1-to-2 byte demultiplexer: the receive-side counterpart of the 2:1 8-bit input mux. It steers one 8-bit input stream to one of two held output channels. Routing is either explicit (select line, mirroring the mux select) or automatic alternation that de-interleaves a ch0/ch1 byte-pair stream. It also counts completed pairs, and sits where a shared byte bus must be split back into two lanes.

## Interface
- WIDTH, 8, data width of input and both output channels
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- din  in  WIDTH  input byte
- din_valid  in  1  din is sampled this cycle
- mode  in  1  0 = explicit routing by s; 1 = automatic alternation
- s  in  1  explicit destination (0 → ch0, 1 → ch1); ignored when mode=1
- sync  in  1  realign alternation: next byte goes to ch0
- o0, o1  out  WIDTH  held channel data registers
- v0, v1  out  1  one-cycle strobe: o0/o1 updated
- pair_valid  out  1  one-cycle strobe: ch0+ch1 pair completed (mode 1 only)
- ptr  out  1  channel the next mode-1 byte will go to
- pair_count  out  8  completed pairs, wraps 255 → 0

## Operation
- Reset (async, immediate): o0=o1=0, v0=v1=0, pair_valid=0, ptr=0, pair_count=0, internal pending=0, mode_q=0.
- Destination on a din_valid cycle:
  - mode=0: destination = s.
  - mode=1: destination = ptr, except when sync=1, which forces destination 0.
- Write: the destination register takes din; its strobe v0/v1 pulses; the other channel's register holds.
- No din_valid: all registers hold; v0, v1 and pair_valid deassert.
- Alternation (mode=1, din_valid=1):
  - Byte to ch0: ptr←1, pending←1.
  - Byte to ch1: ptr←0. If pending=1, pair_valid pulses and pair_count increments. pending←0.
- sync=1 without din_valid: ptr←0, pending←0.
- sync=1 with din_valid in mode 1: byte goes to ch0, ptr←1, pending←1 (sync wins over the old ptr).
- sync in mode 0: clears ptr and pending; the byte routes by s.
- Mode change: mode_q is the registered mode.
  - On any cycle where mode≠mode_q: ptr←0 and pending←0 before routing, so the byte is treated as the first of a fresh alignment.
  - mode=0 bytes never change ptr, pending or pair_count after that cycle.
- pair_count is 8-bit modulo; it is not affected by sync or mode.

## Timing
- Single clock domain, fully registered outputs; no combinational path from inputs to outputs.
- Latency 1: din/din_valid sampled at edge N → o*, v*, pair_valid, ptr, pair_count updated after edge N, visible for cycle N+1.
- Strobes are exactly one cycle wide per accepted byte. Back-to-back din_valid every cycle is supported at full rate.
- pair_valid is coincident with the v1 strobe of the completing byte. pair_count shows the incremented value in that same cycle.
- Reset asserted mid-stream clears all state asynchronously. The first byte after reset release goes to ch0 in mode 1.

## Test plan
- Reset then idle: rst pulse with din_valid=0 → all outputs 0, ptr=0, pair_count=0.
- Explicit routing, mode=0:
  - Stimulus: din=0xA5,s=0 then din=0x3C,s=1.
  - Response: o0=0xA5 with v0 pulse, then o1=0x3C with v1 pulse. o0 holds 0xA5. pair_valid never asserts. ptr stays 0.
- Alternation, mode=1:
  - Stimulus: din_valid continuous with 0x11,0x22,0x33,0x44.
  - Response: o0=0x11, then o1=0x22 with pair_valid and pair_count=1, then o0=0x33, then o1=0x44 with pair_count=2. ptr toggles 1,0,1,0.
- Sync realign:
  - Stimulus: in mode 1, send 0x55 (ptr→1), then sync=1 with din=0x66.
  - Response: o0=0x66, no pair_valid, ptr=1, pending restarted. Next byte 0x77 goes to o1 with pair_valid.
- Wrap and gaps:
  - Stimulus: 256 pairs with random idle cycles between bytes.
  - Response: pair_count returns to 0 and registers hold across gaps. An async rst mid-pair (after the ch0 byte) returns ptr=0 and pair_count=0 before the next edge.
- Mode switch mid-pair:
  - Stimulus: mode=1 byte to ch0, then mode=0,s=1 byte, then mode=1 byte.
  - Response: the second byte is written to o1 with no pair_valid. The third byte goes to ch0 (realigned).
